buzzer_sequencer: RTL and testbench
===================================

# buzzer_sequencer

Parametrised beep-pattern generator driving an external active or passive buzzer from the 100 MHz system clock. On a `start` pulse it plays a programmable number of beeps. Each beep has programmable on/off durations, counted in prescaled ticks. The output is either a DC level (active buzzer) or a square-wave tone (passive buzzer). It replaces the fixed three-beep 2 Hz generator in the microwave controller's end-of-cook and alert paths, and adds abort, busy and done handshakes plus continuous-repeat mode.

## Interface
Parameters:
- `TICK_DIV`, 25_000_000 — clk cycles per duration tick (0.25 s at 100 MHz); must be ≥1
- `DUR_W`, 8 — width of `on_ticks` / `off_ticks`
- `CNT_W`, 4 — width of `beep_count`; all-ones means repeat forever
- `TONE_W`, 17 — width of `tone_half`

Ports:
- `clk` in 1 — system clock, 100 MHz
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — one-cycle request; sampled only in IDLE
- `stop` in 1 — abort; level-sampled every cycle
- `mode` in 1 — 0 = DC level, 1 = square-wave tone
- `beep_count` in CNT_W — number of beeps
- `on_ticks` in DUR_W — beep-on length in ticks
- `off_ticks` in DUR_W — gap length in ticks
- `tone_half` in TONE_W — tone half-period in clk cycles
- `buzzer` out 1 — buzzer drive, registered
- `busy` out 1 — high in ON/OFF states
- `done` out 1 — one-cycle pulse on normal completion

## Operation
- **State machine:** IDLE, ON, OFF.
- **Config latch:** on an accepted `start` (IDLE, `start`=1, `stop`=0), `mode`, `beep_count`, `on_ticks`, `off_ticks` and `tone_half` are latched. Input changes while busy have no effect.
- **Zero clamps:** `on_ticks`=0 is treated as 1. `tone_half`=0 is treated as 1.
- **`beep_count`=0:** start is accepted with no beep. `done` pulses the next cycle; the block stays in IDLE and `busy` never rises.
- **IDLE → ON** on an accepted start. The prescaler and tick counter clear, the beep counter loads, and the tone phase resets low.
- **ON:**
  - Lasts exactly eff_on × `TICK_DIV` cycles.
  - At the end of ON, the remaining-beep count decrements unless it is in repeat mode (latched all-ones).
  - If the count reaches 0: go to IDLE and pulse `done`.
  - Otherwise, if `off_ticks`=0: re-enter ON directly (buzzer stays continuous, tone phase is not reset).
  - Otherwise: go to OFF.
- **OFF:** lasts exactly `off_ticks` × `TICK_DIV` cycles, then returns to ON with the tone phase reset.
- **Buzzer output:**
  - `mode`=0: `buzzer`=1 throughout ON.
  - `mode`=1: `buzzer` toggles every eff `tone_half` cycles during ON, starting low.
  - `buzzer`=0 in OFF and IDLE.
- **Stop:**
  - In ON/OFF: next cycle is IDLE with `buzzer`=0 and `busy`=0. No `done` pulse.
  - In IDLE: `stop` has priority over `start`; the start is dropped.
- **Start while busy:** ignored.
- **Counter widths:** the prescaler is ceil(log2(`TICK_DIV`)) bits and the tick counter is DUR_W bits. No counter wraps during a phase.

## Timing
- **Reset values:** state IDLE; `buzzer`=0, `busy`=0, `done`=0; all counters 0.
- **Start latency:** with `start` high in cycle N, `busy`=1 and `buzzer` becomes active (=1 for `mode`=0) in cycle N+1.
- **Phase lengths:** an ON phase occupies cycles N+1 … N+eff_on·`TICK_DIV`. OFF phases follow back-to-back with no idle cycle.
- **Completion:** `done`=1 in the first IDLE cycle after the last ON, concurrent with `busy`=0 and `buzzer`=0. Done is asserted for exactly one cycle.
- **Reset mid-operation:** outputs go to reset values immediately (asynchronous). Operation restarts only on a new `start` after `rst` deasserts.
- **Restart:** `start` in the same cycle `done` is high is accepted.

## Test plan
- **DC pattern:** `TICK_DIV`=10, `beep_count`=3, `on_ticks`=2, `off_ticks`=1, `mode`=0 → three 20-cycle highs separated by 10-cycle lows; `busy` high 80 cycles; `done` one cycle at start+81.
- **Tone mode:** `TICK_DIV`=10, `beep_count`=1, `on_ticks`=4, `tone_half`=5, `mode`=1 → 40 ON cycles; buzzer low 5 cycles, high 5 cycles, repeating (4 periods); then `done`.
- **Abort mid-ON:** `stop` pulsed 7 cycles into the second beep → `buzzer`=0 and `busy`=0 next cycle; no `done`; a subsequent start is accepted normally.
- **Zero and degenerate values:** `beep_count`=0 → `done` at start+1, `busy` never high. `on_ticks`=0 → 1-tick beep. `off_ticks`=0, `beep_count`=2, `on_ticks`=1 → buzzer high continuously for 20 cycles.
- **Repeat mode:** `beep_count`=15 (CNT_W=4) → beeps continue past 20 beeps with no `done`, until `stop`.
- **Start collisions:** `start` while busy → ignored, pattern unchanged. `start`+`stop` together in IDLE → nothing happens. Async `rst` mid-OFF → all outputs 0 immediately.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// Beep-pattern generator for an active (DC) or passive (tone) buzzer.
// A start pulse latches the configuration and plays beep_count beeps of
// on_ticks ticks each, separated by off_ticks-tick gaps. A tick is TICK_DIV
// clk cycles. beep_count all-ones repeats until stop.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; buzzer low; done may pulse here
// S_ON   | beep active; buzzer high (DC) or toggling (tone)
// S_OFF  | gap between beeps; buzzer low
module buzzer_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DUR_W    = 8,
    parameter int CNT_W    = 4,
    parameter int TONE_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [CNT_W-1:0]  beep_count,
    input  logic [DUR_W-1:0]  on_ticks,
    input  logic [DUR_W-1:0]  off_ticks,
    input  logic [TONE_W-1:0] tone_half,
    output logic              buzzer,
    output logic              busy,
    output logic              done
);

    // A one-bit prescaler is kept for TICK_DIV=1; it then sits at its terminal value.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t            state, state_n;
    logic              mode_q, mode_n;
    logic [CNT_W-1:0]  rem_q, rem_n, rem_dec;
    logic [DUR_W-1:0]  on_q, on_n, off_q, off_n, on_eff, phase_last;
    logic [TONE_W-1:0] half_q, half_n, half_eff;
    logic [PRE_W-1:0]  pre_q, pre_n;
    logic [DUR_W-1:0]  tck_q, tck_n;
    logic [TONE_W-1:0] tcnt_q, tcnt_n;
    logic              tph_q, tph_n;
    logic              buzzer_n, busy_n, done_n;
    logic              tick_end, phase_end;

    assign on_eff     = (on_q == '0) ? DUR_W'(1) : on_q;
    assign half_eff   = (half_q == '0) ? TONE_W'(1) : half_q;
    assign phase_last = (state == S_ON) ? (on_eff - 1'b1) : (off_q - 1'b1);
    assign tick_end   = (pre_q == PRE_LAST);
    assign phase_end  = tick_end && (tck_q == phase_last);
    // All-ones count is repeat mode and is never decremented.
    assign rem_dec    = (rem_q == '1) ? rem_q : (rem_q - 1'b1);

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            rem_q  <= '0;
            on_q   <= '0;
            off_q  <= '0;
            half_q <= '0;
            pre_q  <= '0;
            tck_q  <= '0;
            tcnt_q <= '0;
            tph_q  <= 1'b0;
            buzzer <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            rem_q  <= rem_n;
            on_q   <= on_n;
            off_q  <= off_n;
            half_q <= half_n;
            pre_q  <= pre_n;
            tck_q  <= tck_n;
            tcnt_q <= tcnt_n;
            tph_q  <= tph_n;
            buzzer <= buzzer_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state, counter advance and next output values.
    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        rem_n    = rem_q;
        on_n     = on_q;
        off_n    = off_q;
        half_n   = half_q;
        pre_n    = pre_q;
        tck_n    = tck_q;
        tcnt_n   = tcnt_q;
        tph_n    = tph_q;
        buzzer_n = 1'b0;
        done_n   = 1'b0;

        // Duration timers and tone divider advance in ON/OFF; overridden below.
        if (state != S_IDLE) begin
            if (tick_end) begin
                pre_n = '0;
                tck_n = tck_q + 1'b1;
            end else begin
                pre_n = pre_q + 1'b1;
            end
            if (tcnt_q == half_eff - 1'b1) begin
                tcnt_n = '0;
                tph_n  = ~tph_q;
            end else begin
                tcnt_n = tcnt_q + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (beep_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = S_ON;
                        mode_n   = mode;
                        rem_n    = beep_count;
                        on_n     = on_ticks;
                        off_n    = off_ticks;
                        half_n   = tone_half;
                        pre_n    = '0;
                        tck_n    = '0;
                        tcnt_n   = '0;
                        tph_n    = 1'b0;
                        buzzer_n = ~mode;
                    end
                end
            end
            S_ON: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (phase_end) begin
                    rem_n = rem_dec;
                    pre_n = '0;
                    tck_n = '0;
                    if (rem_dec == '0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (off_q == '0) begin
                        // Back-to-back beeps: tone phase runs on uninterrupted.
                        buzzer_n = mode_q ? tph_n : 1'b1;
                    end else begin
                        state_n = S_OFF;
                    end
                end else begin
                    buzzer_n = mode_q ? tph_n : 1'b1;
                end
            end
            S_OFF: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (phase_end) begin
                    state_n  = S_ON;
                    pre_n    = '0;
                    tck_n    = '0;
                    tcnt_n   = '0;
                    tph_n    = 1'b0;
                    buzzer_n = ~mode_q;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Leaving the active states returns every counter to its idle value.
        if (state_n == S_IDLE) begin
            pre_n  = '0;
            tck_n  = '0;
            tcnt_n = '0;
            tph_n  = 1'b0;
        end
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with TICK_DIV=10.
module tb_buzzer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  beep_count = '0;
    logic [7:0]  on_ticks = '0;
    logic [7:0]  off_ticks = '0;
    logic [16:0] tone_half = '0;
    logic        buzzer, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    buzzer_sequencer #(.TICK_DIV(10), .DUR_W(8), .CNT_W(4), .TONE_W(17)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .beep_count(beep_count), .on_ticks(on_ticks), .off_ticks(off_ticks),
        .tone_half(tone_half), .buzzer(buzzer), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mode;
        logic [3:0]  cnt;
        logic [7:0]  on;
        logic [7:0]  off;
        logic [16:0] half;
        bit          poke;
        int          e_busy;
        int          e_high;
        int          e_rises;
        int          e_done_at;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plays one pattern and measures 120 cycles from start+1.
    task automatic run(input vec_t v, output int busy_n, output int high_n,
                       output int rises_n, output int done_at, output int done_n);
        logic prev;
        @(negedge clk);
        mode = v.mode; beep_count = v.cnt; on_ticks = v.on;
        off_ticks = v.off; tone_half = v.half; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~v.mode; beep_count = 4'd7; on_ticks = 8'd9;
        off_ticks = 8'd0; tone_half = 17'd2;
        busy_n = 0; high_n = 0; rises_n = 0; done_at = -1; done_n = 0; prev = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            if (busy) busy_n++;
            if (buzzer) high_n++;
            if (buzzer && !prev) rises_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            prev = buzzer;
            start = v.poke && (k == 5 || k == 25);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int b, h, r, da, dn;
        run(v, b, h, r, da, dn);
        check({v.name, " busy"}, b, v.e_busy);
        check({v.name, " high"}, h, v.e_high);
        check({v.name, " rises"}, r, v.e_rises);
        check({v.name, " done_at"}, da, v.e_done_at);
        check({v.name, " done_pulses"}, dn, 1);
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        logic prev;

        //        name        mode cnt on    off   half    poke busy high rises done_at
        vecs[0] = '{"dc3",    1'b0, 4'd3, 8'd2, 8'd1, 17'd5, 1'b1, 80, 60, 3, 81};
        vecs[1] = '{"tone",   1'b1, 4'd1, 8'd4, 8'd1, 17'd5, 1'b0, 40, 20, 4, 41};
        vecs[2] = '{"on0",    1'b0, 4'd1, 8'd0, 8'd3, 17'd5, 1'b0, 10, 10, 1, 11};
        vecs[3] = '{"off0",   1'b0, 4'd2, 8'd1, 8'd0, 17'd5, 1'b0, 20, 20, 1, 21};
        vecs[4] = '{"cnt0",   1'b0, 4'd0, 8'd2, 8'd1, 17'd5, 1'b0,  0,  0, 0,  1};
        vecs[5] = '{"half0",  1'b1, 4'd1, 8'd1, 8'd1, 17'd0, 1'b0, 10,  5, 5, 11};
        vecs[6] = '{"tone2",  1'b1, 4'd2, 8'd1, 8'd2, 17'd3, 1'b0, 40,  8, 4, 41};
        vecs[7] = '{"toneoff0",1'b1,4'd2, 8'd1, 8'd0, 17'd3, 1'b0, 20,  9, 3, 21};

        // Reset state
        #1;
        check("rst buzzer", int'(buzzer), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort 7 cycles into the second beep
        @(negedge clk);
        mode = 1'b0; beep_count = 4'd3; on_ticks = 8'd2; off_ticks = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (36) @(negedge clk);
        check("abort pre buzzer", int'(buzzer), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort buzzer", int'(buzzer), 0);
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) cnt_a++;
            @(negedge clk);
        end
        check("abort no done", cnt_a, 0);
        run_vec(vecs[2]);

        // Repeat mode: 25 beeps, no done, then stop
        @(negedge clk);
        mode = 1'b0; beep_count = 4'hF; on_ticks = 8'd1; off_ticks = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; prev = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            if (buzzer && !prev) cnt_a++;
            if (done) cnt_b++;
            if (busy) cnt_c++;
            prev = buzzer;
            @(negedge clk);
        end
        check("repeat rises", cnt_a, 25);
        check("repeat done", cnt_b, 0);
        check("repeat busy", cnt_c, 500);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("repeat stop busy", int'(busy), 0);
        check("repeat stop done", int'(done), 0);

        // start and stop together in IDLE
        @(negedge clk);
        beep_count = 4'd1; on_ticks = 8'd1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done || buzzer) cnt_a++;
            @(negedge clk);
        end
        check("start+stop idle", cnt_a, 0);

        // Asynchronous reset in the middle of an OFF gap
        @(negedge clk);
        mode = 1'b0; beep_count = 4'd3; on_ticks = 8'd2; off_ticks = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("pre-rst busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", int'(busy), 0);
        check("async rst buzzer", int'(buzzer), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy || done || buzzer) cnt_a++;
            @(negedge clk);
        end
        check("post-rst idle", cnt_a, 0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
